instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the core's immediate decode path: packs opcode, register, funct fields and a 32-bit immediate into a legal RV32I instruction word.
- Range-checks the immediate for the target format before packing.
- Streams accepted words into instruction memory at an auto-incrementing address.
- Used by the boot/test loader to fill instruction memory before the 3-stage core is released from reset.

Parameters:
ADDR_W, 12, instruction-memory byte-address width; write address wraps modulo 2^ADDR_W
BASE_ADDR, 0, byte address loaded into the write pointer on reset and on restart

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
restart  input  1  synchronous pulse: write pointer := BASE_ADDR, word_count := 0
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request
opcode  input  7  instruction opcode, using the shared OPCODE_* defines
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field, used by R-type only
imm  input  32  signed byte immediate; for U-type, the full value with imm[11:0] = 0
mem_we  output  1  instruction-memory write strobe
mem_ready  input  1  memory accepts the write this cycle
mem_addr  output  ADDR_W  word-aligned write byte address
mem_wdata  output  32  encoded instruction
word_count  output  16  number of words written since reset/restart, saturates at 0xFFFF
err  output  1  sticky error flag
err_code  output  2  first error seen: 01 out of range, 10 misaligned, 11 unsupported opcode
clr_err  input  1  synchronous clear of err and err_code

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, err=0, err_code=00, state=IDLE.
- FSM state IDLE:
  - in_ready=1.
  - Accept when in_valid & in_ready: register all inputs, go to CHECK.
- FSM state CHECK (one cycle, in_ready=0):
  - Compute the packed word and the error class.
  - If no error: load mem_wdata, go to WRITE.
  - Else: set err (if not already set) and latch err_code (first error wins); no write; pointer unchanged; return to IDLE.
- FSM state WRITE:
  - mem_we=1; mem_addr and mem_wdata held stable.
  - On mem_ready: mem_addr += 4 (wraps), word_count += 1 (saturating), go to IDLE.
- Latency: accept to mem_we = 2 cycles; minimum throughput 1 word per 3 cycles.
- Packing by opcode:
  - R (0110011): funct7|rs2|rs1|funct3|rd|op; imm ignored.
  - I / LOAD / JALR: imm[11:0]|rs1|funct3|rd|op. Range: imm[31:11] all equal.
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op. Same range rule.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op. Range: imm[31:12] all equal. imm[0] must be 0, else misaligned.
  - LUI / AUIPC: imm[31:12]|rd|op. imm[11:0] nonzero → out of range.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. Range: imm[31:20] all equal. imm[0] must be 0, else misaligned.
  - Any other opcode → unsupported.
- Error priority within one request: unsupported > misaligned > out of range.
- Simultaneous events:
  - clr_err and a new error in the same cycle: the new error wins (err=1, new code).
  - restart during WRITE: the pending write completes to its latched address; pointer and count are then forced to BASE_ADDR and 0. restart takes priority over the increment in the same cycle.
- Asynchronous reset mid-WRITE drops the write immediately (mem_we=0); no partial state is retained.

Test Plan:
- Reset, then addi x1,x0,-1 (op 0010011, rd=1, imm=0xFFFFFFFF), mem_ready=1 → mem_wdata=0xFFF00093 at addr 0x000; word_count=1; err=0.
- beq x1,x2,+8 (op 1100011, rs1=1, rs2=2, imm=8), then jal x1,+2048 (op 1101111, rd=1, imm=0x800) → writes 0x00208463 at 0x000 and 0x001000EF at 0x004.
- Error cases:
  - addi with imm=2048 → err=1, err_code=01, no mem_we, mem_addr unchanged.
  - Then branch with imm=3 → err_code stays 01.
  - clr_err → err=0.
- mem_ready held low 3 cycles during WRITE → mem_we=1 and mem_addr/mem_wdata stable for 4 cycles; in_ready=0 throughout; single increment on release.
- Wrap and restart:
  - ADDR_W=4, write 5 words → addresses 0x0, 0x4, 0x8, 0xC, 0x0.
  - restart → next word at BASE_ADDR with word_count=1.
- Assert rst in the cycle mem_we=1 → mem_we=0 asynchronously, mem_addr=BASE_ADDR, word_count=0; opcode 0000000 after release → err_code=11.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and instruction-memory loader: range-checks and packs
// opcode/register/funct/immediate fields, then streams words to memory at an auto-incrementing address.
module instr_encoder_loader #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic signed [31:0] imm,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [15:0]        word_count,
    output logic               err,
    output logic [1:0]         err_code,
    input  logic               clr_err
);

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_RANGE = 2'b01;
    localparam logic [1:0] E_MISAL = 2'b10;
    localparam logic [1:0] E_UNSUP = 2'b11;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

    state_t state, state_nxt;

    logic [6:0]         opcode_p0;
    logic [4:0]         rd_p0, rs1_p0, rs2_p0;
    logic [2:0]         funct3_p0;
    logic [6:0]         funct7_p0;
    logic signed [31:0] imm_p0;

    logic [1:0]  cls_p1;
    logic [31:0] word_p1;
    logic        accept;
    logic        restart_pend;

    // Error class with priority unsupported > misaligned > out of range.
    function automatic logic [1:0] classify(input logic [6:0] op, input logic signed [31:0] v);
        logic [1:0] c;
        c = E_NONE;
        case (op)
            OPCODE_OP: c = E_NONE;
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR, OPCODE_STORE:
                c = (&v[31:11] || ~|v[31:11]) ? E_NONE : E_RANGE;
            OPCODE_BRANCH:
                if (v[0])                          c = E_MISAL;
                else if (!(&v[31:12] || ~|v[31:12])) c = E_RANGE;
            OPCODE_LUI, OPCODE_AUIPC:
                c = (|v[11:0]) ? E_RANGE : E_NONE;
            OPCODE_JAL:
                if (v[0])                          c = E_MISAL;
                else if (!(&v[31:20] || ~|v[31:20])) c = E_RANGE;
            default: c = E_UNSUP;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] pack(input logic [6:0] op, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic signed [31:0] v);
        logic [31:0] w;
        w = '0;
        case (op)
            OPCODE_OP:                               w = {f7, s2, s1, f3, d, op};
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: w = {v[11:0], s1, f3, d, op};
            OPCODE_STORE:  w = {v[11:5], s2, s1, f3, v[4:0], op};
            OPCODE_BRANCH: w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
            OPCODE_LUI, OPCODE_AUIPC:                w = {v[31:12], d, op};
            OPCODE_JAL:    w = {v[20], v[10:1], v[11], v[19:12], d, op};
            default:       w = '0;
        endcase
        return w;
    endfunction

    assign accept = (state == IDLE) && in_valid && in_ready;
    assign mem_we = (state == WRITE);

    // p0: request capture on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            opcode_p0 <= opcode;
            rd_p0     <= rd;
            rs1_p0    <= rs1;
            rs2_p0    <= rs2;
            funct3_p0 <= funct3;
            funct7_p0 <= funct7;
            imm_p0    <= imm;
        end
    end

    // p1: classification and packing, consumed in CHECK
    always_comb begin
        cls_p1  = classify(opcode_p0, imm_p0);
        word_p1 = pack(opcode_p0, rd_p0, rs1_p0, rs2_p0, funct3_p0, funct7_p0, imm_p0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CHECK;
            CHECK:   state_nxt = (cls_p1 == E_NONE) ? WRITE : IDLE;
            WRITE:   if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p2: memory write, pointer and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            mem_addr     <= BASE;
            mem_wdata    <= '0;
            word_count   <= '0;
            err          <= 1'b0;
            err_code     <= E_NONE;
            restart_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == IDLE);

            if (state == CHECK && cls_p1 == E_NONE)
                mem_wdata <= word_p1;

            // A restart seen mid-write is deferred until the write lands at its latched address.
            if (state == WRITE) begin
                if (mem_ready) begin
                    restart_pend <= 1'b0;
                    if (restart || restart_pend) begin
                        mem_addr   <= BASE;
                        word_count <= '0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(4);
                        if (word_count != 16'hFFFF)
                            word_count <= word_count + 16'd1;
                    end
                end else if (restart) begin
                    restart_pend <= 1'b1;
                end
            end else if (restart) begin
                mem_addr   <= BASE;
                word_count <= '0;
            end

            if (state == CHECK && cls_p1 != E_NONE) begin
                err <= 1'b1;
                if (!err || clr_err)
                    err_code <= cls_p1;
            end else if (clr_err) begin
                err      <= 1'b0;
                err_code <= E_NONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed plan steps plus randomized requests
// checked against a field-arithmetic reference model; a 4-bit-address twin checks wrap-around.
module tb_instr_encoder_loader;

    logic               clk = 1'b0;
    logic               rst, restart, in_valid, mem_ready, clr_err;
    logic [6:0]         opcode_i, funct7_i;
    logic [4:0]         rd_i, rs1_i, rs2_i;
    logic [2:0]         funct3_i;
    logic signed [31:0] imm_i;

    logic        in_ready, mem_we, err;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] word_count;
    logic [1:0]  err_code;

    logic        in_ready4, mem_we4, err4;
    logic [3:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic [15:0] word_count4;
    logic [1:0]  err_code4;

    int tests = 0;
    int fails = 0;
    int exp_addr = 0;
    int exp_count = 0;
    bit exp_err = 0;
    bit [1:0] exp_code = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode_i), .rd(rd_i), .rs1(rs1_i), .rs2(rs2_i), .funct3(funct3_i),
        .funct7(funct7_i), .imm(imm_i), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
        .err(err), .err_code(err_code), .clr_err(clr_err)
    );

    instr_encoder_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready4),
        .opcode(opcode_i), .rd(rd_i), .rs1(rs1_i), .rs2(rs2_i), .funct3(funct3_i),
        .funct7(funct7_i), .imm(imm_i), .mem_we(mem_we4), .mem_ready(mem_ready),
        .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .word_count(word_count4),
        .err(err4), .err_code(err_code4), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    // Reference encoder built from signed ranges and shift/mask arithmetic.
    function automatic void model(input bit [6:0] op, input bit [4:0] d, input bit [4:0] s1,
                                  input bit [4:0] s2, input bit [2:0] f3, input bit [6:0] f7,
                                  input int v, output bit [31:0] w, output bit [1:0] c);
        bit [31:0] u;
        bit [31:0] base;
        u    = v;
        base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        w = 0;
        c = 0;
        case (op)
            7'b0110011: w = (32'(f7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7);
            7'b0010011, 7'b0000011, 7'b1100111: begin
                if (v < -2048 || v > 2047) c = 1;
                w = ((u & 32'hFFF) << 20) | base | (32'(d) << 7);
            end
            7'b0100011: begin
                if (v < -2048 || v > 2047) c = 1;
                w = (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base | ((u & 32'h1F) << 7);
            end
            7'b1100011: begin
                if ((u & 1) != 0) c = 2;
                else if (v < -4096 || v > 4095) c = 1;
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(s2) << 20) | base
                    | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
            end
            7'b0110111, 7'b0010111: begin
                if ((u & 32'hFFF) != 0) c = 1;
                w = (u & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
            end
            7'b1101111: begin
                if ((u & 1) != 0) c = 2;
                else if (v < -(1 << 20) || v > (1 << 20) - 1) c = 1;
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
                    | (((u >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
            end
            default: c = 3;
        endcase
    endfunction

    task automatic send(input bit [6:0] op, input bit [4:0] d, input bit [4:0] s1, input bit [4:0] s2,
                        input bit [2:0] f3, input bit [6:0] f7, input int v, input int delay,
                        input bit do_restart, input bit do_rst);
        bit [31:0] w;
        bit [1:0]  c;
        int n;
        model(op, d, s1, s2, f3, f7, v, w, c);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("in_ready_idle", in_ready, 1);
        opcode_i = op; rd_i = d; rs1_i = s1; rs2_i = s2; funct3_i = f3; funct7_i = f7; imm_i = v;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        chk("in_ready_check", in_ready, 0);
        @(negedge clk);
        if (c != 0) begin
            if (!exp_err) exp_code = c;
            exp_err = 1;
            chk("err_no_we", mem_we, 0);
            chk("err_flag", err, 1);
            chk("err_code", err_code, exp_code);
            chk("err_addr", mem_addr, exp_addr);
        end else begin
            chk("we", mem_we, 1);
            chk("wdata", mem_wdata, w);
            chk("addr", mem_addr, exp_addr);
            chk("addr4", mem_addr4, exp_addr % 16);
            for (int k = 0; k < delay; k++) begin
                if (k == 0 && do_restart) restart = 1;
                @(negedge clk);
                restart = 0;
                chk("hold_we", mem_we, 1);
                chk("hold_wdata", mem_wdata, w);
                chk("hold_addr", mem_addr, exp_addr);
                chk("hold_busy", in_ready, 0);
            end
            if (do_rst) begin
                #2 rst = 1;
                #1;
                chk("rst_we", mem_we, 0);
                chk("rst_addr", mem_addr, 0);
                chk("rst_count", word_count, 0);
                chk("rst_ready", in_ready, 0);
                @(negedge clk);
                rst = 0;
                exp_addr = 0; exp_count = 0; exp_err = 0; exp_code = 0;
                return;
            end
            mem_ready = 1;
            @(negedge clk);
            mem_ready = 0;
            if (do_restart) begin
                exp_addr = 0; exp_count = 0;
            end else begin
                exp_addr = (exp_addr + 4) % 4096;
                if (exp_count < 65535) exp_count++;
            end
            chk("we_drop", mem_we, 0);
            chk("count", word_count, exp_count);
            chk("addr_next", mem_addr, exp_addr);
            chk("addr4_next", mem_addr4, exp_addr % 16);
        end
        chk("err_track", err, exp_err);
    endtask

    task automatic do_restart_idle();
        restart = 1;
        @(negedge clk);
        restart = 0;
        exp_addr = 0; exp_count = 0;
        chk("restart_count", word_count, 0);
        chk("restart_addr", mem_addr, 0);
    endtask

    task automatic do_clr_err();
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        exp_err = 0; exp_code = 0;
        chk("clr_err", err, 0);
        chk("clr_code", err_code, 0);
    endtask

    initial begin
        bit [6:0] ops [10];
        bit [6:0] op;
        int v, sel, dly;
        bit rs;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
        rst = 1; restart = 0; in_valid = 0; mem_ready = 0; clr_err = 0;
        opcode_i = 0; rd_i = 0; rs1_i = 0; rs2_i = 0; funct3_i = 0; funct7_i = 0; imm_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        rst = 0;

        send(7'b0010011, 1, 0, 0, 0, 0, -1, 0, 0, 0);
        chk("addi_count", word_count, 1);
        do_restart_idle();
        send(7'b1100011, 0, 1, 2, 0, 0, 8, 0, 0, 0);
        send(7'b1101111, 1, 0, 0, 0, 0, 32'h800, 0, 0, 0);

        send(7'b0010011, 1, 0, 0, 0, 0, 2048, 0, 0, 0);
        send(7'b1100011, 0, 1, 2, 0, 0, 3, 0, 0, 0);
        chk("first_err_wins", err_code, 2'b01);
        do_clr_err();

        send(7'b0010011, 3, 4, 0, 0, 0, 5, 3, 0, 0);

        do_restart_idle();
        for (int i = 0; i < 5; i++) send(7'b0110011, 5'(i), 1, 2, 0, 7'h20, 0, 0, 0, 0);
        do_restart_idle();
        send(7'b0110111, 7, 0, 0, 0, 0, 32'h12345000, 0, 0, 0);
        chk("restart_next_count", word_count, 1);

        send(7'b0100011, 0, 3, 4, 2, 0, -4, 2, 1, 0);
        send(7'b0010011, 1, 0, 0, 0, 0, 9, 1, 0, 1);
        send(7'b0000000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("unsup_code", err_code, 2'b11);
        do_clr_err();

        for (int i = 0; i < 40; i++) begin
            op  = ops[$urandom_range(0, 9)];
            sel = $urandom_range(0, 9);
            case (op)
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011:
                    v = (sel < 7) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom);
                7'b1100011: begin
                    v = int'($urandom_range(0, 8191)) - 4096;
                    if (sel < 7) v = v & ~1;
                    if (sel == 9) v = int'($urandom);
                end
                7'b1101111: begin
                    v = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
                    if (sel < 7) v = v & ~1;
                    if (sel == 9) v = int'($urandom);
                end
                7'b0110111, 7'b0010111: begin
                    v = int'($urandom & 32'hFFFFF000);
                    if (sel >= 8) v = v | 1;
                end
                default: v = int'($urandom);
            endcase
            dly = $urandom_range(0, 3);
            rs  = (dly > 0) && ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) do_clr_err();
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), v, dly, rs, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
